// File: rtl/data_untransposer_if.sv
// Bundle of the untransposer's host control, MVU read-port and output-stream signals.
// The master side is the environment (host plus MVU port); the slave side is the untransposer.
interface data_untransposer_if #(
    parameter int XLEN         = 32,
    parameter int MVU_ADDR_LEN = 15,
    parameter int MVU_DATA_LEN = 64
);
    logic                    start;
    logic [31:0]             prec;
    logic [31:0]             baddr;
    logic                    signed_i;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    rdc_en;
    logic                    rdc_grnt;
    logic [MVU_ADDR_LEN-1:0] rdc_addr;
    logic [MVU_DATA_LEN-1:0] rdc_word;
    logic                    o_valid;
    logic                    o_ready;
    logic [XLEN-1:0]         o_word;
    logic                    o_last;

    modport master (
        output start, prec, baddr, signed_i, rdc_grnt, rdc_word, o_ready,
        input  busy, done, err, rdc_en, rdc_addr, o_valid, o_word, o_last
    );

    modport slave (
        input  start, prec, baddr, signed_i, rdc_grnt, rdc_word, o_ready,
        output busy, done, err, rdc_en, rdc_addr, o_valid, o_word, o_last
    );
endinterface

// File: rtl/data_untransposer.sv
// Reads P bit-planes of one vector from an MVU data RAM and streams the vector back
// to the host as one right-aligned (optionally sign-extended) element per XLEN word.
module data_untransposer #(
    parameter int NUM_WORDS     = 64,
    parameter int XLEN          = 32,
    parameter int MVU_ADDR_LEN  = 15,
    parameter int MVU_DATA_LEN  = 64,
    parameter int MAX_DATA_PREC = 16
) (
    input logic               clk,
    input logic               rst,
    data_untransposer_if.slave bus
);
    localparam int PW     = $clog2(MAX_DATA_PREC + 1);
    localparam int PIDX_W = $clog2(MAX_DATA_PREC);
    localparam int EW     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

    state_t                  state_q;
    logic                    busy_q, done_q, err_q, rdc_en_q, grant_q;
    logic                    o_valid_q, o_last_q, sign_q;
    logic [MVU_ADDR_LEN-1:0] rdc_addr_q;
    logic [XLEN-1:0]         o_word_q, word_d;
    logic [PW-1:0]           prec_q, issued_q, received_q, prec_clamped;
    logic [EW-1:0]           elem_q, elem_sel;
    logic [MVU_DATA_LEN-1:0] planes_q [MAX_DATA_PREC];
    logic                    unused_baddr;
    int                      p_int;

    assign prec_clamped = (bus.prec > 32'(MAX_DATA_PREC)) ? PW'(MAX_DATA_PREC) : bus.prec[PW-1:0];
    assign unused_baddr = ^bus.baddr[31:MVU_ADDR_LEN];
    // word_d always holds the element that becomes visible at the next output update
    assign elem_sel     = (state_q == OUT) ? elem_q + EW'(1) : '0;

    always_comb begin
        word_d = '0;
        p_int  = int'(prec_q);
        for (int b = 0; b < XLEN; b++) begin
            if (b < p_int) word_d[b] = planes_q[PIDX_W'(p_int - 1 - b)][elem_sel];
            else           word_d[b] = sign_q & planes_q[0][elem_sel];
        end
    end

    // Plane buffer carries data only, so it stays out of the reset domain
    always_ff @(posedge clk) begin
        if (state_q == READ && grant_q) planes_q[received_q[PIDX_W-1:0]] <= bus.rdc_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdc_en_q   <= 1'b0;
            grant_q    <= 1'b0;
            rdc_addr_q <= '0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            o_word_q   <= '0;
            prec_q     <= '0;
            sign_q     <= 1'b0;
            issued_q   <= '0;
            received_q <= '0;
            elem_q     <= '0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            grant_q <= rdc_en_q & bus.rdc_grnt;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.prec == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= READ;
                            busy_q     <= 1'b1;
                            rdc_en_q   <= 1'b1;
                            rdc_addr_q <= bus.baddr[MVU_ADDR_LEN-1:0];
                            prec_q     <= prec_clamped;
                            sign_q     <= bus.signed_i;
                            issued_q   <= '0;
                            received_q <= '0;
                        end
                    end
                end
                READ: begin
                    if (rdc_en_q && bus.rdc_grnt) begin
                        issued_q   <= issued_q + PW'(1);
                        rdc_addr_q <= rdc_addr_q + MVU_ADDR_LEN'(1);
                        if (issued_q + PW'(1) == prec_q) rdc_en_q <= 1'b0;
                    end
                    if (grant_q) received_q <= received_q + PW'(1);
                    if (received_q == prec_q) begin
                        state_q   <= OUT;
                        o_valid_q <= 1'b1;
                        o_word_q  <= word_d;
                        o_last_q  <= (NUM_WORDS == 1);
                        elem_q    <= '0;
                    end
                end
                OUT: begin
                    if (bus.o_ready) begin
                        if (elem_q == EW'(NUM_WORDS - 1)) begin
                            state_q   <= IDLE;
                            o_valid_q <= 1'b0;
                            o_last_q  <= 1'b0;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            elem_q   <= elem_q + EW'(1);
                            o_word_q <= word_d;
                            o_last_q <= (elem_q + EW'(1) == EW'(NUM_WORDS - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdc_en   = rdc_en_q;
    assign bus.rdc_addr = rdc_addr_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_word   = o_word_q;
    assign bus.o_last   = o_last_q;
endmodule

// File: tb/tb_data_untransposer.sv
// Bench for data_untransposer: a bit-plane RAM model drives the read port and every
// output element is compared with a lane value rebuilt arithmetically from that RAM.
module tb_data_untransposer;
    localparam int NW = 64;
    localparam int XL = 32;
    localparam int AL = 15;
    localparam int DL = 64;
    localparam int MP = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_untransposer_if #(.XLEN(XL), .MVU_ADDR_LEN(AL), .MVU_DATA_LEN(DL)) bus ();

    data_untransposer #(
        .NUM_WORDS(NW), .XLEN(XL), .MVU_ADDR_LEN(AL), .MVU_DATA_LEN(DL), .MAX_DATA_PREC(MP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DL-1:0] ram [0:(1<<AL)-1];
    logic [31:0]   lane_val [NW];

    // RAM answers one cycle after a granted request
    always @(posedge clk) begin
        if (bus.rdc_en && bus.rdc_grnt) bus.rdc_word <= ram[bus.rdc_addr];
    end

    int passed = 0;
    int total  = 0;

    logic [XL-1:0] got_words[$];
    bit            got_last[$];
    logic [AL-1:0] got_addr[$];
    int first_valid, done_cnt, err_cnt, stall_viol, hold_viol;
    bit busy_after_start, busy_at_end, timeout;

    function automatic logic [31:0] model_elem(int p, logic [31:0] ba, bit sg, int lane);
        int pp;
        logic [31:0] v;
        logic [AL-1:0] a;
        pp = (p > MP) ? MP : p;
        v  = '0;
        for (int j = 0; j < pp; j++) begin
            a = AL'(ba + 32'(j));
            v = (v << 1) | 32'(ram[a][lane]);
        end
        if (sg && v[pp-1]) v = v | ~((32'd1 << pp) - 32'd1);
        return v;
    endfunction

    task automatic load_ram(input logic [31:0] ba, input int p);
        for (int j = 0; j < p; j++)
            for (int k = 0; k < NW; k++)
                ram[AL'(ba + 32'(j))][k] = lane_val[k][p-1-j];
    endtask

    task automatic fill_rand(input logic [31:0] ba, input int p);
        for (int j = 0; j < p; j++) ram[AL'(ba + 32'(j))] = {$urandom(), $urandom()};
    endtask

    // gmode: 0 grant tied high, 1 pattern 1-0-0, 2 random; inj: cycle of an extra start (-1 none)
    task automatic run_vector(input int p, input logic [31:0] ba, input bit sg,
                              input int gmode, input bit rrand, input int inj);
        bit seen_done, stalled, addr_wait, held_last;
        int post;
        logic [XL-1:0] held_word;
        logic [AL-1:0] held_addr;
        got_words.delete(); got_last.delete(); got_addr.delete();
        first_valid = -1; done_cnt = 0; err_cnt = 0; stall_viol = 0; hold_viol = 0;
        timeout = 1'b0; seen_done = 1'b0; post = 0; stalled = 1'b0; addr_wait = 1'b0;
        busy_after_start = 1'b0; held_last = 1'b0; held_word = '0; held_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == 0) || (cyc == inj);
            if (cyc == 0) begin
                bus.prec = 32'(p); bus.baddr = ba; bus.signed_i = sg;
            end else if (cyc == inj) begin
                bus.prec = 32'd3; bus.baddr = 32'h0100; bus.signed_i = ~sg;
            end
            case (gmode)
                0:       bus.rdc_grnt = 1'b1;
                1:       bus.rdc_grnt = (cyc % 3 == 0);
                default: bus.rdc_grnt = 1'($urandom_range(0, 1));
            endcase
            bus.o_ready = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) busy_after_start = bus.busy;
            if (bus.done) done_cnt++;
            if (bus.err) err_cnt++;
            if (stalled && (!bus.o_valid || bus.o_word !== held_word || bus.o_last !== held_last))
                stall_viol++;
            if (addr_wait && (!bus.rdc_en || bus.rdc_addr !== held_addr)) hold_viol++;
            if (bus.o_valid && first_valid < 0) first_valid = cyc;
            if (bus.rdc_en && bus.rdc_grnt) got_addr.push_back(bus.rdc_addr);
            if (bus.o_valid && bus.o_ready) begin
                got_words.push_back(bus.o_word);
                got_last.push_back(bus.o_last);
            end
            stalled   = bus.o_valid && !bus.o_ready;
            held_word = bus.o_word;
            held_last = bus.o_last;
            addr_wait = bus.rdc_en && !bus.rdc_grnt;
            held_addr = bus.rdc_addr;
            if (bus.done) seen_done = 1'b1;
            if (seen_done) begin
                post++;
                if (post == 3) break;
            end
        end
        if (!seen_done) timeout = 1'b1;
        busy_at_end = bus.busy;
        bus.start   = 1'b0;
        bus.o_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.rdc_en !== 1'b0) $display("FAIL reset_rdc_en: got %b expected 0", bus.rdc_en); else passed++;
        total++; if (bus.o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); else passed++;
        total++; if ({bus.done, bus.err, bus.o_last} !== 3'b000)
            $display("FAIL reset_pulses: got %b expected 000", {bus.done, bus.err, bus.o_last}); else passed++;
        total++; if (bus.rdc_addr !== '0) $display("FAIL reset_rdc_addr: got %h expected 0", bus.rdc_addr); else passed++;
        total++; if (bus.o_word !== '0) $display("FAIL reset_o_word: got %h expected 0", bus.o_word); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int nl;
        for (int k = 0; k < NW; k++) lane_val[k] = 32'(k);
        load_ram(32'h0010, 8);
        run_vector(8, 32'h0010, 1'b0, 0, 1'b0, -1);
        total++; if (timeout) $display("FAIL basic_timeout: got timeout expected done"); else passed++;
        total++; if (got_addr.size() != 8) $display("FAIL basic_reads: got %0d expected 8", got_addr.size()); else passed++;
        for (int j = 0; j < got_addr.size() && j < 8; j++) begin
            total++;
            if (got_addr[j] !== AL'(32'h10 + 32'(j)))
                $display("FAIL basic_addr[%0d]: got %h expected %h", j, got_addr[j], 32'h10 + 32'(j));
            else passed++;
        end
        total++; if (got_words.size() != NW) $display("FAIL basic_count: got %0d expected %0d", got_words.size(), NW); else passed++;
        nl = 0;
        for (int k = 0; k < got_words.size() && k < NW; k++) begin
            if (got_last[k]) nl++;
            total++;
            if (got_words[k] !== 32'(k)) $display("FAIL basic_word[%0d]: got %h expected %h", k, got_words[k], 32'(k));
            else passed++;
        end
        total++; if (nl != 1 || got_last.size() != NW || !got_last[NW-1])
            $display("FAIL basic_last: got %0d lasts expected one on word 63", nl); else passed++;
        total++; if (done_cnt != 1) $display("FAIL basic_done: got %0d expected 1", done_cnt); else passed++;
        total++; if (first_valid != 11) $display("FAIL basic_latency: got %0d expected 11", first_valid); else passed++;
        total++; if (busy_after_start !== 1'b1) $display("FAIL basic_busy_rise: got %b expected 1", busy_after_start); else passed++;
        total++; if (busy_at_end !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy_at_end); else passed++;
    endtask

    task automatic test_signed;
        lane_val[0] = 32'h8;
        lane_val[1] = 32'h7;
        for (int k = 2; k < NW; k++) lane_val[k] = $urandom_range(0, 15);
        load_ram(32'h0200, 4);
        run_vector(4, 32'h0200, 1'b1, 0, 1'b0, -1);
        total++; if (got_words.size() != NW) $display("FAIL signed_count: got %0d expected %0d", got_words.size(), NW); else passed++;
        total++; if (got_words.size() < 2 || got_words[0] !== 32'hFFFF_FFF8)
            $display("FAIL signed_word0: got %h expected fffffff8", got_words.size() > 0 ? got_words[0] : 32'h0); else passed++;
        total++; if (got_words.size() < 2 || got_words[1] !== 32'h0000_0007)
            $display("FAIL signed_word1: got %h expected 00000007", got_words.size() > 1 ? got_words[1] : 32'h0); else passed++;
        for (int k = 2; k < got_words.size() && k < NW; k++) begin
            total++;
            if (got_words[k] !== model_elem(4, 32'h0200, 1'b1, k))
                $display("FAIL signed_word[%0d]: got %h expected %h", k, got_words[k], model_elem(4, 32'h0200, 1'b1, k));
            else passed++;
        end
    endtask

    task automatic test_wrap;
        logic [AL-1:0] exp_a [4];
        exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000; exp_a[3] = 15'h0001;
        fill_rand(32'h7FFE, 4);
        run_vector(4, 32'h7FFE, 1'b0, 0, 1'b0, -1);
        total++; if (got_addr.size() != 4) $display("FAIL wrap_reads: got %0d expected 4", got_addr.size()); else passed++;
        for (int j = 0; j < got_addr.size() && j < 4; j++) begin
            total++;
            if (got_addr[j] !== exp_a[j]) $display("FAIL wrap_addr[%0d]: got %h expected %h", j, got_addr[j], exp_a[j]);
            else passed++;
        end
        for (int k = 0; k < got_words.size() && k < NW; k++) begin
            total++;
            if (got_words[k] !== model_elem(4, 32'h7FFE, 1'b0, k))
                $display("FAIL wrap_word[%0d]: got %h expected %h", k, got_words[k], model_elem(4, 32'h7FFE, 1'b0, k));
            else passed++;
        end
    endtask

    task automatic test_stall;
        int p, nl;
        logic [31:0] ba;
        bit sg;
        for (int r = 0; r < 3; r++) begin
            p  = (r == 0) ? MP : $urandom_range(1, MP);
            ba = $urandom();
            sg = 1'($urandom_range(0, 1));
            fill_rand(ba, p);
            run_vector(p, ba, sg, (r == 2) ? 2 : 1, 1'b1, -1);
            total++; if (timeout) $display("FAIL stall_timeout[%0d]: got timeout expected done", r); else passed++;
            total++; if (hold_viol != 0) $display("FAIL stall_addr_hold[%0d]: got %0d changes expected 0", r, hold_viol); else passed++;
            total++; if (stall_viol != 0) $display("FAIL stall_word_hold[%0d]: got %0d changes expected 0", r, stall_viol); else passed++;
            total++; if (got_addr.size() != p) $display("FAIL stall_reads[%0d]: got %0d expected %0d", r, got_addr.size(), p); else passed++;
            total++; if (got_words.size() != NW) $display("FAIL stall_count[%0d]: got %0d expected %0d", r, got_words.size(), NW); else passed++;
            nl = 0;
            for (int k = 0; k < got_words.size() && k < NW; k++) begin
                if (got_last[k]) nl++;
                total++;
                if (got_words[k] !== model_elem(p, ba, sg, k))
                    $display("FAIL stall_word[%0d][%0d]: got %h expected %h", r, k, got_words[k], model_elem(p, ba, sg, k));
                else passed++;
            end
            total++; if (nl != 1 || got_last.size() != NW || !got_last[NW-1])
                $display("FAIL stall_last[%0d]: got %0d lasts expected one on final word", r, nl); else passed++;
            total++; if (done_cnt != 1) $display("FAIL stall_done[%0d]: got %0d expected 1", r, done_cnt); else passed++;
        end
    endtask

    task automatic test_err_clamp_busy;
        @(negedge clk);
        bus.start = 1'b1; bus.prec = 32'd0; bus.baddr = 32'h0040; bus.signed_i = 1'b0; bus.rdc_grnt = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.err !== 1'b1) $display("FAIL err_pulse: got %b expected 1", bus.err); else passed++;
        total++; if (bus.busy !== 1'b0 || bus.rdc_en !== 1'b0)
            $display("FAIL err_idle: got busy=%b rdc_en=%b expected 0 0", bus.busy, bus.rdc_en); else passed++;
        @(negedge clk);
        total++; if (bus.err !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL err_one_cycle: got err=%b busy=%b expected 0 0", bus.err, bus.busy); else passed++;

        fill_rand(32'h1000, 20);
        run_vector(20, 32'h1000, 1'b0, 0, 1'b0, 10);
        total++; if (got_addr.size() != MP) $display("FAIL clamp_reads: got %0d expected %0d", got_addr.size(), MP); else passed++;
        total++; if (got_words.size() != NW) $display("FAIL clamp_count: got %0d expected %0d", got_words.size(), NW); else passed++;
        for (int k = 0; k < got_words.size() && k < NW; k++) begin
            total++;
            if (got_words[k] !== model_elem(20, 32'h1000, 1'b0, k))
                $display("FAIL clamp_word[%0d]: got %h expected %h", k, got_words[k], model_elem(20, 32'h1000, 1'b0, k));
            else passed++;
        end
        total++; if (done_cnt != 1 || err_cnt != 0)
            $display("FAIL clamp_pulses: got done=%0d err=%0d expected 1 0", done_cnt, err_cnt); else passed++;

        fill_rand(32'h2000, 5);
        run_vector(5, 32'h2000, 1'b1, 0, 1'b0, 12);
        total++; if (got_words.size() != NW) $display("FAIL busy_start_count: got %0d expected %0d", got_words.size(), NW); else passed++;
        for (int k = 0; k < got_words.size() && k < NW; k++) begin
            total++;
            if (got_words[k] !== model_elem(5, 32'h2000, 1'b1, k))
                $display("FAIL busy_start_word[%0d]: got %h expected %h", k, got_words[k], model_elem(5, 32'h2000, 1'b1, k));
            else passed++;
        end
        total++; if (done_cnt != 1 || busy_at_end !== 1'b0)
            $display("FAIL busy_start_ignored: got done=%0d busy=%b expected 1 0", done_cnt, busy_at_end); else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        bit hit;
        fill_rand(32'h3000, MP);
        @(negedge clk);
        bus.start = 1'b1; bus.prec = 32'd16; bus.baddr = 32'h3000; bus.signed_i = 1'b0;
        bus.rdc_grnt = 1'b1; bus.o_ready = 1'b1;
        n = 0; hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rdc_en && bus.rdc_grnt) n++;
            if (n == 5) hit = 1'b1;
        end
        total++; if (!hit) $display("FAIL reset_mid_grants: got %0d expected 5", n); else passed++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.rdc_en !== 1'b0 || bus.busy !== 1'b0 || bus.o_valid !== 1'b0)
            $display("FAIL reset_mid_clear: got rdc_en=%b busy=%b o_valid=%b expected 0 0 0",
                     bus.rdc_en, bus.busy, bus.o_valid); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        fill_rand(32'h5000, 9);
        run_vector(9, 32'h5000, 1'b1, 0, 1'b0, -1);
        total++; if (got_addr.size() != 9) $display("FAIL after_reset_reads: got %0d expected 9", got_addr.size()); else passed++;
        total++; if (got_words.size() != NW) $display("FAIL after_reset_count: got %0d expected %0d", got_words.size(), NW); else passed++;
        for (int k = 0; k < got_words.size() && k < NW; k++) begin
            total++;
            if (got_words[k] !== model_elem(9, 32'h5000, 1'b1, k))
                $display("FAIL after_reset_word[%0d]: got %h expected %h", k, got_words[k], model_elem(9, 32'h5000, 1'b1, k));
            else passed++;
        end
        total++; if (first_valid != 12) $display("FAIL after_reset_latency: got %0d expected 12", first_valid); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.prec = '0; bus.baddr = '0; bus.signed_i = 1'b0;
        bus.rdc_grnt = 1'b0; bus.o_ready = 1'b0; bus.rdc_word = '0;
        for (int a = 0; a < (1 << AL); a++) ram[a] = '0;
        test_reset();
        test_basic();
        test_signed();
        test_wrap();
        test_stall();
        test_err_clamp_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
